// File: rtl/cp0_if.sv
// cp0_if -- bundle of the M-stage signals exchanged between the pipeline and
// the coprocessor-0 block.
//
//   A1        pipeline -> cp0   mfc0 read address (rd)
//   A2        pipeline -> cp0   mtc0 write address (rd)
//   CP0In     pipeline -> cp0   mtc0 write data (GPR rt)
//   en        pipeline -> cp0   mtc0 write enable, qualified at M
//   VPC       pipeline -> cp0   PC of the instruction in M
//   BDIn      pipeline -> cp0   M instruction is in a branch delay slot
//   ExcCodeIn pipeline -> cp0   exception code of the M instruction (0 = none)
//   HWInt     pipeline -> cp0   level-sensitive external interrupt lines
//   EXLClr    pipeline -> cp0   eret in M
//   CP0Out    cp0 -> pipeline   combinational mfc0 read data
//   EPCOut    cp0 -> pipeline   current EPC (eret target)
//   Req       cp0 -> pipeline   flush / redirect request
interface cp0_if;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] CP0In;
   logic        en;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] CP0Out;
   logic [31:0] EPCOut;
   logic        Req;

   modport master (
      output A1, A2, CP0In, en, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
      input  CP0Out, EPCOut, Req
   );

   modport slave (
      input  A1, A2, CP0In, en, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
      output CP0Out, EPCOut, Req
   );
endinterface

// File: rtl/cp0.sv
// cp0 -- coprocessor-0 system-control block for the five-stage MIPS pipeline.
// Holds SR (12), Cause (13), EPC (14) and PRId (15); arbitrates hardware
// interrupts against synchronous exceptions; raises the flush/redirect
// request; serves mfc0 reads and mtc0 writes.
//
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    cp0_if.slave: read/write ports, M-stage exception info, interrupt
//          lines, eret strobe, read data, EPC and request outputs
module cp0 #(
   parameter logic [31:0] PRID = 32'h2023_0707
) (
   input  logic  clk,
   input  logic  reset,
   cp0_if.slave  bus
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;

   // SR fields
   logic [5:0]  im;
   logic        exl;
   logic        ie;
   // Cause fields
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  exc_code;
   // EPC
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic        req;
   logic        sr_write;
   logic        epc_write;
   logic [31:0] sr_word;
   logic [31:0] cause_word;
   logic [31:0] epc_next;

   // Requests are evaluated on live inputs; EXL masks both sources.
   always_comb begin
      int_req = (|(bus.HWInt & im)) & ie & ~exl;
      exc_req = (bus.ExcCodeIn != 5'd0) & ~exl;
      req     = int_req | exc_req;
   end

   always_comb begin
      sr_write  = bus.en && (bus.A2 == ADDR_SR);
      epc_write = bus.en && (bus.A2 == ADDR_EPC);
      // A delay-slot instruction restarts at its branch; wraps modulo 2^32.
      epc_next  = bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
   end

   always_comb begin
      sr_word    = {16'h0000, im, 8'h00, exl, ie};
      cause_word = {cause_bd, 15'h0000, cause_ip, 3'b000, exc_code, 2'b00};
   end

   // Read port sees only registered state, never same-cycle write data.
   always_comb begin
      bus.CP0Out = '0;
      case (bus.A1)
         ADDR_SR:    bus.CP0Out = sr_word;
         ADDR_CAUSE: bus.CP0Out = cause_word;
         ADDR_EPC:   bus.CP0Out = epc;
         ADDR_PRID:  bus.CP0Out = PRID;
         default:    bus.CP0Out = '0;
      endcase
   end

   assign bus.EPCOut = epc;
   assign bus.Req    = req;

   always_ff @(posedge clk) begin
      if (!reset) begin
         im       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         cause_bd <= 1'b0;
         cause_ip <= '0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         // Pending-interrupt view tracks the lines unconditionally.
         cause_ip <= bus.HWInt;
         if (req) begin
            // Taking a request drops any same-cycle mtc0 and eret.
            exl      <= 1'b1;
            cause_bd <= bus.BDIn;
            exc_code <= int_req ? 5'd0 : bus.ExcCodeIn;
            epc      <= epc_next;
         end else begin
            if (sr_write) begin
               im  <= bus.CP0In[15:10];
               exl <= bus.CP0In[1];
               ie  <= bus.CP0In[0];
            end
            if (epc_write) begin
               epc <= bus.CP0In;
            end
            // Placed after the SR write so eret wins the EXL bit.
            if (bus.EXLClr) begin
               exl <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cp0.sv
// tb_cp0 -- scoreboard bench for cp0. Stimulus drives inputs just after each
// rising edge and queues the expected CP0Out/EPCOut/Req for that cycle; an
// independent monitor samples on the falling edge and compares.
module tb_cp0;
   localparam logic [31:0] PRID_VAL = 32'h2023_0707;

   logic clk;
   logic reset;
   logic sample;
   int   n_checks;
   int   n_pass;

   typedef struct {
      string       name;
      logic [31:0] out;
      logic [31:0] epc;
      logic        req;
   } exp_t;

   exp_t exp_q[$];

   cp0_if bus ();

   cp0 #(.PRID(PRID_VAL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one queued expectation per sampled cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sample) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL scoreboard_underflow: sample with empty queue");
            end else begin
               e = exp_q.pop_front();
               n_checks++;
               if (bus.CP0Out === e.out) n_pass++;
               else $display("FAIL %s.CP0Out: got %h expected %h", e.name, bus.CP0Out, e.out);
               n_checks++;
               if (bus.EPCOut === e.epc) n_pass++;
               else $display("FAIL %s.EPCOut: got %h expected %h", e.name, bus.EPCOut, e.epc);
               n_checks++;
               if (bus.Req === e.req) n_pass++;
               else $display("FAIL %s.Req: got %b expected %b", e.name, bus.Req, e.req);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue the expectation for this cycle, then advance through the edge.
   task automatic chk(input string nm, input logic [4:0] a1,
                      input logic [31:0] o, input logic [31:0] e, input logic r);
      bus.A1 = a1;
      sample = 1'b1;
      exp_q.push_back('{nm, o, e, r});
      @(posedge clk);
      #1;
      sample = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      sample = 1'b0;
      reset = 1'b0;
      bus.A1 = '0; bus.A2 = '0; bus.CP0In = '0; bus.en = 1'b0;
      bus.VPC = '0; bus.BDIn = 1'b0; bus.ExcCodeIn = '0; bus.HWInt = '0;
      bus.EXLClr = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_sr",    5'd12, 32'h0, 32'h0, 1'b0);
      chk("rst_cause", 5'd13, 32'h0, 32'h0, 1'b0);
      chk("rst_prid",  5'd15, PRID_VAL, 32'h0, 1'b0);
      reset = 1'b1;

      // mtc0 SR all ones; no same-cycle visibility
      bus.en = 1'b1; bus.A2 = 5'd12; bus.CP0In = 32'hFFFF_FFFF;
      chk("sr_wr_same", 5'd12, 32'h0, 32'h0, 1'b0);
      bus.en = 1'b0;
      chk("sr_all1",   5'd12, 32'h0000_FC03, 32'h0, 1'b0);
      chk("prid",      5'd15, PRID_VAL, 32'h0, 1'b0);

      // SR = IM[10] | IE, clears EXL
      bus.en = 1'b1; bus.A2 = 5'd12; bus.CP0In = 32'h0000_0401;
      tick();
      bus.en = 1'b0;

      // Interrupt beats RI exception
      bus.HWInt = 6'b000001; bus.ExcCodeIn = 5'd10; bus.VPC = 32'h0000_3008; bus.BDIn = 1'b0;
      chk("int_req",    5'd12, 32'h0000_0401, 32'h0, 1'b1);
      chk("int_cause",  5'd13, 32'h0000_0400, 32'h0000_3008, 1'b0);
      chk("int_sr",     5'd12, 32'h0000_0403, 32'h0000_3008, 1'b0);

      // EXL masks Ov and a masked-in interrupt
      bus.ExcCodeIn = 5'd12; bus.VPC = 32'h0000_5000;
      chk("exl_mask_c", 5'd13, 32'h0000_0400, 32'h0000_3008, 1'b0);
      chk("exl_mask_e", 5'd14, 32'h0000_3008, 32'h0000_3008, 1'b0);

      // SR = 0, quiet inputs
      bus.en = 1'b1; bus.A2 = 5'd12; bus.CP0In = 32'h0; bus.HWInt = '0; bus.ExcCodeIn = '0;
      tick();
      bus.en = 1'b0;

      // Syscall in delay slot
      bus.ExcCodeIn = 5'd8; bus.BDIn = 1'b1; bus.VPC = 32'h0000_3010;
      chk("sys_req",    5'd12, 32'h0, 32'h0000_3008, 1'b1);
      bus.ExcCodeIn = '0; bus.BDIn = 1'b0;
      chk("sys_cause",  5'd13, 32'h8000_0020, 32'h0000_300C, 1'b0);
      chk("sys_sr",     5'd12, 32'h0000_0002, 32'h0000_300C, 1'b0);
      bus.EXLClr = 1'b1;
      chk("eret_cyc",   5'd14, 32'h0000_300C, 32'h0000_300C, 1'b0);
      bus.EXLClr = 1'b0;
      chk("eret_sr",    5'd12, 32'h0, 32'h0000_300C, 1'b0);

      // eret and mtc0 SR in the same cycle: EXL cleared, IM/IE written
      bus.en = 1'b1; bus.A2 = 5'd12; bus.CP0In = 32'h0000_0403; bus.EXLClr = 1'b1;
      tick();
      bus.en = 1'b0; bus.EXLClr = 1'b0;
      chk("eret_vs_wr", 5'd12, 32'h0000_0401, 32'h0000_300C, 1'b0);

      // AdEL at VPC 0 in delay slot with simultaneous mtc0 EPC: wraps, write dropped
      bus.ExcCodeIn = 5'd4; bus.VPC = 32'h0; bus.BDIn = 1'b1;
      bus.en = 1'b1; bus.A2 = 5'd14; bus.CP0In = 32'hDEAD_BEEF;
      chk("epc_race",   5'd14, 32'h0000_300C, 32'h0000_300C, 1'b1);
      bus.en = 1'b0; bus.ExcCodeIn = '0; bus.BDIn = 1'b0;
      chk("epc_wrap",   5'd14, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
      chk("adel_cause", 5'd13, 32'h8000_0010, 32'hFFFF_FFFC, 1'b0);

      // Cause is read-only
      bus.en = 1'b1; bus.A2 = 5'd13; bus.CP0In = 32'hFFFF_FFFF;
      tick();
      bus.en = 1'b0;
      chk("cause_ro",   5'd13, 32'h8000_0010, 32'hFFFF_FFFC, 1'b0);

      // Clear EXL via mtc0, then interrupt + Ov + eret together
      bus.en = 1'b1; bus.A2 = 5'd12; bus.CP0In = 32'h0000_0401;
      tick();
      bus.en = 1'b0;
      bus.HWInt = 6'b000001; bus.ExcCodeIn = 5'd12; bus.EXLClr = 1'b1;
      bus.VPC = 32'h0000_4000; bus.BDIn = 1'b0;
      chk("int_eret",   5'd13, 32'h8000_0010, 32'hFFFF_FFFC, 1'b1);
      bus.EXLClr = 1'b0;
      chk("int_eret_sr", 5'd12, 32'h0000_0403, 32'h0000_4000, 1'b0);

      // IP lags HWInt by one cycle
      bus.HWInt = 6'b101010;
      chk("ip_lag",     5'd13, 32'h0000_0400, 32'h0000_4000, 1'b0);
      chk("ip_new",     5'd13, 32'h0000_A800, 32'h0000_4000, 1'b0);
      chk("unmapped",   5'd3,  32'h0, 32'h0000_4000, 1'b0);

      // Reset mid-handler
      bus.ExcCodeIn = '0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      bus.HWInt = '0;
      chk("mid_rst_sr", 5'd12, 32'h0, 32'h0, 1'b0);
      chk("mid_rst_c",  5'd13, 32'h0, 32'h0, 1'b0);
      chk("mid_rst_e",  5'd14, 32'h0, 32'h0, 1'b0);

      tick();
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 system-control block for the five-stage MIPS pipeline. Sits beside the M stage and is the consuming end of the exception and privileged-instruction flags that the instruction decoder raises (`exc_RI`, `exc_SYS`, `eret`, `mtc0`, `BD`, overflow). It does four things:
- holds the SR, Cause, EPC and PRId registers;
- arbitrates hardware interrupts against synchronous exceptions;
- issues the flush/redirect request to the pipeline;
- serves `mfc0` reads and `mtc0` writes.

## Interface
Parameters:
- `PRID`, default 32'h2023_0707: read-only value returned for register 15.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset. It is sampled on the rising edge of `clk`; 0 means reset.
- `A1`  in  5  read address, for `mfc0` rd.
- `A2`  in  5  write address, for `mtc0` rd.
- `CP0In`  in  32  write data (GPR rt value for `mtc0`).
- `en`  in  1  write enable for `mtc0`; the decoder's CP0_WE qualified at M.
- `VPC`  in  32  PC of the instruction currently in M.
- `BDIn`  in  1  the M instruction sits in a branch delay slot.
- `ExcCodeIn`  in  5  exception code of the M instruction. Values: 0 none, 4 AdEL, 5 AdES, 8 Syscall, 10 RI, 12 Ov.
- `HWInt`  in  6  external interrupt lines, level-sensitive.
- `EXLClr`  in  1  `eret` in M; clears EXL.
- `CP0Out`  out  32  combinational read data for `A1`.
- `EPCOut`  out  32  current EPC register; the `eret` target.
- `Req`  out  1  combinational exception/interrupt request. Asserting it flushes the pipeline and redirects the PC to 32'h0000_4180.

## Operation
Register fields (all unlisted bits read as 0):
- SR (12): IM[15:10], EXL[1], IE[0].
- Cause (13): BD[31], IP[15:10], ExcCode[6:2].
- EPC (14): 32 bits.
- PRId (15): constant `PRID`.
- Any other `A1` returns 0.

Request generation (combinational):
- IntReq = |(HWInt & IM) & IE & ~EXL.
- ExcReq = (ExcCodeIn != 0) & ~EXL.
- Req = IntReq | ExcReq.
- Interrupt has priority over exception. When IntReq=1 the recorded ExcCode is 0.

On a clock edge with Req=1:
- EXL <= 1.
- Cause.BD <= BDIn.
- Cause.ExcCode <= IntReq ? 0 : ExcCodeIn.
- EPC <= BDIn ? VPC-4 : VPC, computed in 32-bit modular arithmetic; wraps at 0.
- Any simultaneous `mtc0` (`en`=1) is discarded.
- Any simultaneous `EXLClr` is ignored; EXL ends at 1.

On a clock edge with Req=0:
- If `EXLClr`=1: EXL <= 0.
- If `en`=1: writes take effect by `A2`.
  - A2=12: IM, EXL and IE take the matching CP0In bits; all other bits are discarded.
  - A2=14: EPC <= CP0In, all 32 bits.
  - A2=13, 15 or any other address: no effect. Cause and PRId are read-only.
- If `en` and `EXLClr` both hit SR in the same cycle, `EXLClr` wins for EXL. The IM and IE writes still apply.

Every edge, independent of Req, `en` and EXL:
- Cause.IP <= HWInt.

`EPCOut` always equals the EPC register. The pipeline forwards any in-flight `mtc0` EPC value to an `eret`; this block does not.

## Timing
- Reset (`reset`=0 at an edge): SR=0, Cause=0, EPC=0. So after reset: `CP0Out`=0 for A1≠15, `EPCOut`=0, `Req`=0. Reset overrides Req, `en` and `EXLClr`.
- Read latency 0: `CP0Out` reflects registers after the last edge and never reflects same-cycle write data.
- `Req` has latency 0 from its inputs.
- Register effects of a request are visible the cycle after the edge. EXL=1 then masks all further requests until an `eret` or an `mtc0` clears it.
- Cause.IP lags `HWInt` by exactly one cycle. The IntReq decision uses live `HWInt`.
- Reset asserted mid-handler (EXL=1) returns the block to the reset state at that edge.

## Test plan
- Reset, then release; `mtc0` A2=12, CP0In=32'hFFFF_FFFF. Next cycle `mfc0` A1=12 reads 32'h0000_FC03 and A1=15 reads `PRID`.
- SR=32'h0000_0401 (IM[10], IE), HWInt=6'b000001, ExcCodeIn=10, VPC=32'h0000_3008, BDIn=0. Req=1 that cycle. Next cycle: Cause=32'h0000_0400, EPC=32'h0000_3008, SR=32'h0000_0403, Req=0.
- ExcCodeIn=8, BDIn=1, VPC=32'h0000_3010, SR=0. Next cycle: Cause=32'h8000_0020, EPC=32'h0000_300C. Then EXLClr=1 for one cycle: SR EXL bit returns to 0.
- EXL=1 with ExcCodeIn=12 and a masked-in HWInt. Req stays 0, and EPC and Cause.ExcCode are unchanged.
- Req=1 in the same cycle as `en`=1, A2=14, CP0In=32'hDEAD_BEEF. EPC ends at the exception VPC, not DEAD_BEEF. `mtc0` A2=13 in any cycle leaves Cause unchanged.
- EXL=1, drive `reset`=0 for one edge. SR, Cause and EPC all read 0, and `EPCOut`=0.
